simple_st0_tap_ctrl: RTL
========================

# simple_st0_tap_ctrl

Sequencer that drives the tap-memory bank's `tap_int` request interface. It issues linear or interleaved row-read sweeps and collects the returned 192-bit rows into a small output FIFO with backpressure. It also arbitrates full-row tap updates and single-lane sub-writes into the bank. It sits between the stage datapath and the tap memory bank of stage 0.

## Interface
Parameters:
- `LANES`, 6, number of 32-bit lanes per row
- `DATA_W`, 32, lane width
- `ADDR_W`, 5, row address width (32 rows)
- `FIFO_D`, 4, output FIFO depth

Ports:
- `clk` in 1: clock
- `reset` in 1: synchronous, active-high
- `start` in 1: begin a sweep (pulse)
- `base_addr` in ADDR_W: first row of the sweep
- `num_rows` in ADDR_W: rows per sweep; 0 is illegal and ignored
- `inter_mode` in 1: interleaved sweep
- `busy` out 1: sweep in progress
- `out_vld` out 1: returned row valid
- `out_ready` in 1: consumer ready
- `out_data` out LANES*DATA_W: returned row
- `out_last` out 1: final row of the sweep
- `upd_vld` in 1: full-row write request
- `upd_ready` out 1: full-row write accepted
- `upd_address` in ADDR_W: full-row write address
- `upd_data` in LANES*DATA_W: full-row write data
- `ld_vld` in 1: lane-write request
- `ld_ready` out 1: lane-write accepted
- `ld_lane` in 3: target lane for the lane write
- `ld_address` in ADDR_W: lane-write address
- `ld_data` in DATA_W: lane-write data
- `tap_rd_vld`, `tap_rd_address`, `tap_inter`, `tap_inter_first` out: read side of `tap_int`
- `tap_wr_vld`, `tap_wr_address`, `tap_wr_data` out: full-row write side
- `tap_sub_vld`, `tap_sub_addr`(3), `tap_sub_data`(DATA_W) out: lane-write side
- `tap_rd_data` in LANES*DATA_W: bank read data; valid 1 cycle after `tap_rd_vld`

## Operation
- States:
  - IDLE: accepts `start`; writes allowed.
  - SWEEP: issues reads; writes blocked.
  - DRAIN: all reads issued; waits for in-flight reads to land and the FIFO to empty; writes allowed.
- Transitions:
  - IDLE→SWEEP on `start & num_rows!=0`. `base_addr`, `num_rows` and `inter_mode` are captured at this point.
  - `start` is ignored outside IDLE.
  - SWEEP→DRAIN in the cycle the last read issues.
  - DRAIN→IDLE when the FIFO is empty and no reads are in flight.
- `busy` = state!=IDLE.
- Read issue:
  - A read issues in SWEEP when count+inflight < FIFO_D. `inflight` counts reads whose data has not yet been written to the FIFO; it is 0–2.
  - `tap_rd_address` = base_addr+i modulo 2^ADDR_W (wraps 31→0), where i = 0..num_rows-1.
- Interleave (`inter_mode`=1):
  - `tap_inter`=1 only on issue cycles.
  - `tap_inter_first`=1 only on the i=0 issue.
  - A stall cycle holds `tap_inter`=0, so the bank's lane counters do not advance.
  - When `inter_mode`=0, `tap_inter` and `tap_inter_first` stay 0.
- Returned data:
  - Pushed into the FIFO together with a last flag (i=num_rows-1).
  - `out_vld` = FIFO non-empty; a pop occurs on `out_vld & out_ready`.
- Writes:
  - `upd_ready` = state!=SWEEP.
  - `ld_ready` = state!=SWEEP & ~upd_vld, so full-row updates have priority.
  - An accepted update drives `tap_wr_vld`=1 with its address and data, and `tap_sub_vld`=0.
  - An accepted lane write drives `tap_sub_vld`=1, `tap_wr_vld`=1, `tap_sub_addr`=`ld_lane` and `tap_wr_address`=`ld_address`.
  - `ld_lane` ≥ LANES is still accepted; the bank drops it.

## Timing
- All `tap_*` outputs and `out_*` outputs are registered.
- `start` accepted in cycle T:
  - first `tap_rd_vld` in T+1;
  - its `tap_rd_data` arrives in T+2 and is written to the FIFO at the end of T+2;
  - `out_vld` rises in T+3.
- With `out_ready` held at 1, one read issues per cycle.
- A write accepted in cycle t appears on `tap_wr_*`/`tap_sub_*` in t+1, as a 1-cycle pulse.
- Reset (including mid-sweep):
  - state→IDLE, FIFO flushed, inflight→0;
  - all outputs 0, except `upd_ready`/`ld_ready`, which read 1 from the first cycle after reset;
  - read data already in the pipeline is discarded; no `out_vld` occurs after reset.
- When the FIFO is full and `out_ready`=0, no read issues and `tap_rd_vld`=0.

## Configuration
- `TAP_CTRL_LD_EN` defined: lane-write port active, as described above.
- `TAP_CTRL_LD_EN` undefined:
  - `ld_ready`, `tap_sub_vld`, `tap_sub_addr` and `tap_sub_data` are tied to 0;
  - `ld_*` inputs are unused;
  - only full-row updates reach `tap_wr_*`.

## Test plan
- Linear sweep: base_addr=3, num_rows=6, out_ready=1.
  - `tap_rd_address` 3..8 in consecutive cycles;
  - 6 `out_vld` beats equal to the rows preloaded at addresses 3..8;
  - `out_last` on the 6th beat;
  - `busy` falls 1 cycle after the last pop.
- Wrap: base_addr=30, num_rows=4 → addresses 30, 31, 0, 1.
- Backpressure: out_ready=0 from start.
  - Exactly 4 reads issue, then `tap_rd_vld` stays 0.
  - Raising `out_ready` resumes issue.
  - Total 12 beats for num_rows=12, in order, with no duplicates.
- Interleave: inter_mode=1, num_rows=12.
  - `tap_inter_first` only on the first issue;
  - `tap_inter`=1 on exactly 12 issue cycles and 0 on stall cycles.
- Writes:
  - upd_vld and ld_vld together in IDLE: update goes first (`tap_wr_vld`=1, `tap_sub_vld`=0), then the lane write (lane 2, addr 7, data 0xDEADBEEF).
  - Both are blocked during SWEEP.
- Reset mid-sweep after 3 issues: no `out_vld` afterwards; `busy`=0; a new start with num_rows=2 completes normally.

Source files
------------

// File: rtl/simple_st0_tap_ctrl.sv
// Stage-0 tap-memory sequencer: row-read sweeps into an output FIFO plus write arbitration.
// Define TAP_CTRL_LD_EN to enable the single-lane write port.
module simple_st0_tap_ctrl #(
  parameter int LANES  = 6,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int FIFO_D = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [ADDR_W-1:0]       num_rows,
  input  logic                    inter_mode,
  output logic                    busy,
  output logic                    out_vld,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic                    out_last,
  input  logic                    upd_vld,
  output logic                    upd_ready,
  input  logic [ADDR_W-1:0]       upd_address,
  input  logic [LANES*DATA_W-1:0] upd_data,
  input  logic                    ld_vld,
  output logic                    ld_ready,
  input  logic [2:0]              ld_lane,
  input  logic [ADDR_W-1:0]       ld_address,
  input  logic [DATA_W-1:0]       ld_data,
  output logic                    tap_rd_vld,
  output logic [ADDR_W-1:0]       tap_rd_address,
  output logic                    tap_inter,
  output logic                    tap_inter_first,
  output logic                    tap_wr_vld,
  output logic [ADDR_W-1:0]       tap_wr_address,
  output logic [LANES*DATA_W-1:0] tap_wr_data,
  output logic                    tap_sub_vld,
  output logic [2:0]              tap_sub_addr,
  output logic [DATA_W-1:0]       tap_sub_data,
  input  logic [LANES*DATA_W-1:0] tap_rd_data
);

  localparam int ROW_W = LANES * DATA_W;
  localparam int PTR_W = $clog2(FIFO_D);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] num_q, num_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic inter_q, inter_d;

  logic issue, iss_last, iss_inter, iss_first;
  logic [ADDR_W-1:0] iss_addr;

  logic rd_vld_q, rd_last_q, inter_o_q, first_o_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic ret_vld_q, ret_last_q;

  logic [ROW_W:0] mem_q [FIFO_D];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic vld_q, push, pop;
  logic [1:0] inflight;
  logic [CNT_W:0] occ;
  logic room;

  logic wr_vld_d, wr_vld_q, sub_vld_d, sub_vld_q;
  logic [ADDR_W-1:0] wr_addr_d, wr_addr_q;
  logic [ROW_W-1:0] wr_data_d, wr_data_q;
  logic [2:0] sub_addr_d, sub_addr_q;
  logic [DATA_W-1:0] sub_data_d, sub_data_q;

  // Credit = FIFO occupancy plus reads whose data is still in the bank pipe.
  assign inflight = {1'b0, rd_vld_q} + {1'b0, ret_vld_q};
  assign occ      = {1'b0, cnt_q} + (CNT_W+1)'(inflight);
  assign room     = occ < (CNT_W+1)'(FIFO_D);
  assign push     = ret_vld_q;
  assign pop      = vld_q && out_ready;

  assign busy      = state_q != IDLE;
  assign upd_ready = state_q != SWEEP;
  assign out_vld   = vld_q;
  assign out_data  = vld_q ? mem_q[rd_ptr_q][ROW_W-1:0] : '0;
  assign out_last  = vld_q & mem_q[rd_ptr_q][ROW_W];

  assign tap_rd_vld      = rd_vld_q;
  assign tap_rd_address  = rd_addr_q;
  assign tap_inter       = inter_o_q;
  assign tap_inter_first = first_o_q;
  assign tap_wr_vld      = wr_vld_q;
  assign tap_wr_address  = wr_addr_q;
  assign tap_wr_data     = wr_data_q;
  assign tap_sub_vld     = sub_vld_q;
  assign tap_sub_addr    = sub_addr_q;
  assign tap_sub_data    = sub_data_q;

`ifdef TAP_CTRL_LD_EN
  assign ld_ready = (state_q != SWEEP) && !upd_vld;
`else
  logic unused_ld;
  assign ld_ready  = 1'b0;
  assign unused_ld = ^{ld_vld, ld_lane, ld_address, ld_data};
`endif

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    num_d     = num_q;
    idx_d     = idx_q;
    inter_d   = inter_q;
    issue     = 1'b0;
    iss_addr  = '0;
    iss_last  = 1'b0;
    iss_inter = 1'b0;
    iss_first = 1'b0;
    unique case (state_q)
      IDLE: begin
        // First row issues straight from the start inputs.
        if (start && num_rows != '0) begin
          base_d    = base_addr;
          num_d     = num_rows;
          inter_d   = inter_mode;
          idx_d     = ADDR_W'(1);
          issue     = 1'b1;
          iss_addr  = base_addr;
          iss_first = 1'b1;
          iss_inter = inter_mode;
          iss_last  = num_rows == ADDR_W'(1);
          state_d   = iss_last ? DRAIN : SWEEP;
        end
      end
      SWEEP: begin
        if (room) begin
          issue     = 1'b1;
          iss_addr  = base_q + idx_q;
          iss_first = idx_q == '0;
          iss_inter = inter_q;
          iss_last  = idx_q == num_q - ADDR_W'(1);
          idx_d     = idx_q + ADDR_W'(1);
          if (iss_last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (inflight == 2'd0 &&
            (cnt_q == '0 || (cnt_q == CNT_W'(1) && pop)))
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop) cnt_d = cnt_q + CNT_W'(1);
    if (!push && pop) cnt_d = cnt_q - CNT_W'(1);
  end

  always_comb begin
    wr_vld_d   = 1'b0;
    wr_addr_d  = '0;
    wr_data_d  = '0;
    sub_vld_d  = 1'b0;
    sub_addr_d = '0;
    sub_data_d = '0;
    if (upd_vld && upd_ready) begin
      wr_vld_d  = 1'b1;
      wr_addr_d = upd_address;
      wr_data_d = upd_data;
    end
`ifdef TAP_CTRL_LD_EN
    else if (ld_vld && ld_ready) begin
      wr_vld_d   = 1'b1;
      wr_addr_d  = ld_address;
      sub_vld_d  = 1'b1;
      sub_addr_d = ld_lane;
      sub_data_d = ld_data;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      base_q     <= '0;
      num_q      <= '0;
      idx_q      <= '0;
      inter_q    <= 1'b0;
      rd_vld_q   <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_addr_q  <= '0;
      inter_o_q  <= 1'b0;
      first_o_q  <= 1'b0;
      ret_vld_q  <= 1'b0;
      ret_last_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      vld_q      <= 1'b0;
      wr_vld_q   <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      sub_vld_q  <= 1'b0;
      sub_addr_q <= '0;
      sub_data_q <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      num_q      <= num_d;
      idx_q      <= idx_d;
      inter_q    <= inter_d;
      rd_vld_q   <= issue;
      rd_last_q  <= iss_last;
      rd_addr_q  <= iss_addr;
      inter_o_q  <= issue & iss_inter;
      first_o_q  <= issue & iss_inter & iss_first;
      ret_vld_q  <= rd_vld_q;
      ret_last_q <= rd_vld_q & rd_last_q;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cnt_q      <= cnt_d;
      vld_q      <= cnt_d != '0;
      wr_vld_q   <= wr_vld_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      sub_vld_q  <= sub_vld_d;
      sub_addr_q <= sub_addr_d;
      sub_data_q <= sub_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {ret_last_q, tap_rd_data};
  end

endmodule
